// File: rtl/max_pool_2x2.sv
// 2x2 max pooling, stride 2, per channel, over a raster-order feature stream.
// Horizontal pairs are reduced on arrival; even rows park their pair maxima in a
// half-width line buffer, odd rows combine with it and emit one vector per window.
// Build option: define MAX_POOL_RELU_EN to clamp negative pooled values to zero.
module max_pool_2x2 #(
    parameter int ROW_WIDTH = 28,
    parameter int NUM_ROWS  = 28,
    parameter int CHANNELS  = 6,
    parameter int DATA_W    = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_features_valid,
    input  logic [CHANNELS*DATA_W-1:0]   i_features_in,
    output logic                         o_features_valid,
    output logic [CHANNELS*DATA_W-1:0]   o_features_out,
    output logic                         o_frame_last
);

    localparam int HalfW = ROW_WIDTH / 2;
    localparam int ColW  = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int RowW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int AddrW = (HalfW > 1) ? $clog2(HalfW) : 1;
    localparam int VecW  = CHANNELS * DATA_W;

    if ((ROW_WIDTH % 2) != 0 || ROW_WIDTH < 2 || (NUM_ROWS % 2) != 0 || NUM_ROWS < 2)
    begin : g_bad_cfg
        $fatal(1, "max_pool_2x2: ROW_WIDTH and NUM_ROWS must be even and at least 2");
    end

    typedef enum logic {PhFill, PhEmit} phase_e;

    phase_e            phase_q;
    logic [ColW-1:0]   col_cnt_q;
    logic [RowW-1:0]   row_cnt_q;
    logic [DATA_W-1:0] held_q [CHANNELS];
    logic [VecW-1:0]   line_buf [HalfW];

    logic              col_last;
    logic              row_last;
    logic              col_odd;
    logic [AddrW-1:0]  lb_addr;
    logic [VecW-1:0]   lb_rd;
    logic [VecW-1:0]   hmax;
    logic [VecW-1:0]   pooled;

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign col_last = (col_cnt_q == ColW'(ROW_WIDTH - 1));
    assign row_last = (row_cnt_q == RowW'(NUM_ROWS - 1));
    assign col_odd  = col_cnt_q[0];
    // Each horizontal pair shares one line-buffer slot, so the column drops its LSB.
    assign lb_addr  = AddrW'(col_cnt_q >> 1);
    assign lb_rd    = line_buf[lb_addr];

    // Pair maximum of the held even pixel and the incoming odd pixel, then window maximum.
    always_comb begin
        hmax   = '0;
        pooled = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hmax[c*DATA_W +: DATA_W]   = smax(held_q[c], i_features_in[c*DATA_W +: DATA_W]);
            pooled[c*DATA_W +: DATA_W] = smax(lb_rd[c*DATA_W +: DATA_W],
                                              hmax[c*DATA_W +: DATA_W]);
`ifdef MAX_POOL_RELU_EN
            if (pooled[c*DATA_W + DATA_W - 1]) begin
                pooled[c*DATA_W +: DATA_W] = '0;
            end
`endif
        end
    end

    // Counters, phase FSM, held pixel and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q          <= PhFill;
            col_cnt_q        <= '0;
            row_cnt_q        <= '0;
            o_features_valid <= 1'b0;
            o_frame_last     <= 1'b0;
            o_features_out   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                held_q[c] <= '0;
            end
        end else begin
            o_features_valid <= 1'b0;
            o_frame_last     <= 1'b0;
            if (i_features_valid) begin
                if (!col_odd) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        held_q[c] <= i_features_in[c*DATA_W +: DATA_W];
                    end
                end else if (phase_q == PhEmit) begin
                    o_features_out   <= pooled;
                    o_features_valid <= 1'b1;
                    o_frame_last     <= row_last && col_last;
                end
                if (col_last) begin
                    col_cnt_q <= '0;
                    row_cnt_q <= row_last ? '0 : row_cnt_q + 1'b1;
                    // Rows alternate fill/emit; NUM_ROWS is even so a frame ends in emit.
                    phase_q   <= (phase_q == PhFill) ? PhEmit : PhFill;
                end else begin
                    col_cnt_q <= col_cnt_q + 1'b1;
                end
            end
        end
    end

    // Line buffer of pair maxima from the even row; written before every read, never reset.
    always_ff @(posedge i_clk) begin
        if (i_features_valid && col_odd && phase_q == PhFill) begin
            line_buf[lb_addr] <= hmax;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: random frames checked against window maxima computed from
// a stored copy of each frame. A 4x4 instance covers the small directed patterns.
`timescale 1ns/1ps
module tb_max_pool_2x2;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int CH = 6;
    localparam int DW = 8;
    localparam int VW = CH * DW;
`ifdef MAX_POOL_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          v_a  = 1'b0;
    logic          v_b  = 1'b0;
    logic [VW-1:0] in_a = '0;
    logic [VW-1:0] in_b = '0;
    logic          ov_a, ol_a, ov_b, ol_b;
    logic [VW-1:0] out_a, out_b;

    int total   = 0;
    int passed  = 0;
    int cyc     = 0;
    bit sel_small = 1'b0;

    byte pix [H][W][CH];
    int  acc_cyc [H][W];
    logic [VW-1:0] got_q[$];
    logic [VW-1:0] exp_q[$];
    int            got_cyc[$];
    int            exp_cyc[$];
    bit            got_last[$];
    bit            exp_last[$];

    max_pool_2x2 dut (
        .i_clk(clk), .i_rst(rst), .i_features_valid(v_a), .i_features_in(in_a),
        .o_features_valid(ov_a), .o_features_out(out_a), .o_frame_last(ol_a)
    );

    max_pool_2x2 #(.ROW_WIDTH(4), .NUM_ROWS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_features_valid(v_b), .i_features_in(in_b),
        .o_features_valid(ov_b), .o_features_out(out_b), .o_frame_last(ol_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every pooled output of the selected instance with its cycle stamp.
    always @(negedge clk) begin
        if (sel_small ? ov_b : ov_a) begin
            got_q.push_back(sel_small ? out_b : out_a);
            got_cyc.push_back(cyc);
            got_last.push_back(sel_small ? ol_b : ol_a);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] rnd_vec();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[VW-1:0];
    endfunction

    function automatic logic [VW-1:0] pack_px(input int r, input int c);
        logic [VW-1:0] v;
        for (int ch = 0; ch < CH; ch++) v[ch*DW +: DW] = pix[r][c][ch];
        return v;
    endfunction

    task automatic drive(input bit v, input logic [VW-1:0] d);
        if (sel_small) begin v_b = v; in_b = d; end
        else begin v_a = v; in_a = d; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin drive(1'b0, rnd_vec()); @(negedge clk); end
    endtask

    task automatic gen_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int ch = 0; ch < CH; ch++) pix[r][c][ch] = byte'($urandom);
    endtask

    task automatic clear_q();
        got_q.delete(); got_cyc.delete(); got_last.delete();
        exp_q.delete(); exp_cyc.delete(); exp_last.delete();
    endtask

    // Drive a stored frame; each pixel is preceded by idle cycles so valid runs at ~duty%.
    task automatic drive_frame(input int w, input int h, input int duty);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                while (int'($urandom_range(0, 99)) >= duty) begin
                    drive(1'b0, rnd_vec());
                    @(negedge clk);
                end
                drive(1'b1, pack_px(r, c));
                acc_cyc[r][c] = cyc + 1;
                @(negedge clk);
            end
        end
    endtask

    // Reference: max over each 2x2 block of the stored frame, windows in raster order.
    task automatic build_expected(input int w, input int h);
        for (int wr = 0; wr < h / 2; wr++) begin
            for (int wc = 0; wc < w / 2; wc++) begin
                logic [VW-1:0] e;
                e = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    int m;
                    m = -1000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (int'(pix[2*wr+dr][2*wc+dc][ch]) > m) m = pix[2*wr+dr][2*wc+dc][ch];
                    if (Relu && m < 0) m = 0;
                    e[ch*DW +: DW] = 8'(m);
                end
                exp_q.push_back(e);
                exp_cyc.push_back(acc_cyc[2*wr+1][2*wc+1]);
                exp_last.push_back(wr == h / 2 - 1 && wc == w / 2 - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ov_a !== 1'b0) $display("FAIL reset valid: got %b want 0", ov_a); else passed++;
        total++; if (ol_a !== 1'b0) $display("FAIL reset last: got %b want 0", ol_a); else passed++;
        total++; if (out_a !== '0) $display("FAIL reset out: got %h want 0", out_a); else passed++;
        total++; if (ov_b !== 1'b0) $display("FAIL reset valid4: got %b want 0", ov_b); else passed++;
        total++; if (ol_b !== 1'b0) $display("FAIL reset last4: got %b want 0", ol_b); else passed++;
        total++; if (out_b !== '0) $display("FAIL reset out4: got %h want 0", out_b); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp_4x4();
        int  want0 [4] = '{5, 7, 13, 15};
        byte b;
        sel_small = 1'b1;
        clear_q();
        gen_random(4, 4);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix[r][c][0] = byte'(r * 4 + c);
        drive_frame(4, 4, 100);
        idle(3);
        build_expected(4, 4);
        total++;
        if (got_q.size() != 4) $display("FAIL ramp count: got %0d want 4", got_q.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_q.size()) begin
                $display("FAIL ramp win %0d: output missing", i);
            end else begin
                b = got_q[i][7:0];
                if (int'(b) != want0[i] || got_last[i] != (i == 3) || got_cyc[i] != exp_cyc[i] ||
                    got_q[i] !== exp_q[i])
                    $display("FAIL ramp win %0d: got ch0 %0d last %0b cyc %0d vec %h want %0d %0b %0d %h",
                             i, b, got_last[i], got_cyc[i], got_q[i], want0[i], i == 3, exp_cyc[i],
                             exp_q[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_negative_window();
        byte b;
        sel_small = 1'b1;
        clear_q();
        gen_random(4, 4);
        pix[0][0][2] = -128; pix[0][1][2] = -3; pix[1][0][2] = -7; pix[1][1][2] = -100;
        drive_frame(4, 4, 100);
        idle(3);
        build_expected(4, 4);
        total++;
        if (got_q.size() == 0) begin
            $display("FAIL negative window: no output");
        end else begin
            b = got_q[0][2*DW +: DW];
            if (int'(b) != (Relu ? 0 : -3))
                $display("FAIL negative window: got %0d want %0d", b, Relu ? 0 : -3);
            else passed++;
        end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size()) $display("FAIL negative win %0d: output missing", i);
            else if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i] || got_last[i] != exp_last[i])
                $display("FAIL negative win %0d: got %h cyc %0d last %0b want %h cyc %0d last %0b",
                         i, got_q[i], got_cyc[i], got_last[i], exp_q[i], exp_cyc[i], exp_last[i]);
            else passed++;
        end
        sel_small = 1'b0;
    endtask

    task automatic test_random_gaps();
        clear_q();
        gen_random(W, H);
        drive_frame(W, H, 40);
        idle(3);
        build_expected(W, H);
        total++;
        if (got_q.size() != 196) $display("FAIL gaps count: got %0d want 196", got_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size()) $display("FAIL gaps win %0d: output missing", i);
            else if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i] || got_last[i] != exp_last[i])
                $display("FAIL gaps win %0d: got %h cyc %0d last %0b want %h cyc %0d last %0b",
                         i, got_q[i], got_cyc[i], got_last[i], exp_q[i], exp_cyc[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        gen_random(W, H);
        drive_frame(W, H, 100);
        build_expected(W, H);
        gen_random(W, H);
        drive_frame(W, H, 100);
        idle(3);
        build_expected(W, H);
        total++;
        if (got_q.size() != 392) $display("FAIL b2b count: got %0d want 392", got_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size()) $display("FAIL b2b win %0d: output missing", i);
            else if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i] || got_last[i] != exp_last[i])
                $display("FAIL b2b win %0d: got %h cyc %0d last %0b want %h cyc %0d last %0b",
                         i, got_q[i], got_cyc[i], got_last[i], exp_q[i], exp_cyc[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        gen_random(W, H);
        for (int i = 0; i < 17 * W + 10; i++) begin
            drive(1'b1, pack_px(i / W, i % W));
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (ov_a !== 1'b0) $display("FAIL midreset valid: got %b want 0", ov_a); else passed++;
        total++; if (ol_a !== 1'b0) $display("FAIL midreset last: got %b want 0", ol_a); else passed++;
        total++; if (out_a !== '0) $display("FAIL midreset out: got %h want 0", out_a); else passed++;
        @(negedge clk);
        drive(1'b0, rnd_vec());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_q();
        gen_random(W, H);
        drive_frame(W, H, 70);
        idle(3);
        build_expected(W, H);
        total++;
        if (got_q.size() != 196) $display("FAIL midreset count: got %0d want 196", got_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size()) $display("FAIL midreset win %0d: output missing", i);
            else if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i] || got_last[i] != exp_last[i])
                $display("FAIL midreset win %0d: got %h cyc %0d last %0b want %h cyc %0d last %0b",
                         i, got_q[i], got_cyc[i], got_last[i], exp_q[i], exp_cyc[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_channels();
        byte b0, b5;
        clear_q();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int ch = 0; ch < CH; ch++)
                    pix[r][c][ch] = (ch == 0) ? 8'sd127 : (ch == 5) ? -8'sd128 : byte'(r + c + 10 * ch);
        drive_frame(W, H, 60);
        idle(3);
        build_expected(W, H);
        total++;
        if (got_q.size() != 196) $display("FAIL chan count: got %0d want 196", got_q.size());
        else passed++;
        foreach (got_q[i]) begin
            b0 = got_q[i][7:0];
            b5 = got_q[i][5*DW +: DW];
            total++;
            if (int'(b0) != 127 || int'(b5) != (Relu ? 0 : -128))
                $display("FAIL chan const %0d: got ch0 %0d ch5 %0d want 127 %0d",
                         i, b0, b5, Relu ? 0 : -128);
            else passed++;
        end
        foreach (exp_q[i]) begin
            total++;
            if (i >= got_q.size()) $display("FAIL chan win %0d: output missing", i);
            else if (got_q[i] !== exp_q[i] || got_cyc[i] != exp_cyc[i] || got_last[i] != exp_last[i])
                $display("FAIL chan win %0d: got %h cyc %0d last %0b want %h cyc %0d last %0b",
                         i, got_q[i], got_cyc[i], got_last[i], exp_q[i], exp_cyc[i], exp_last[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp_4x4();
        test_negative_window();
        test_random_gaps();
        test_back_to_back();
        test_reset_mid();
        test_channels();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Pooling stage directly upstream of the post-processing block. Its outputs drive that block's i_features_valid / i_features_in[0:5].
- Consumes the conv layer's 6-channel signed 8-bit feature stream in raster order. Performs 2x2 max pooling, stride 2, per channel.
- Holds one half-width line buffer of horizontal maxima. Emits one pooled 6-channel vector per 2x2 window.

Parameters:
- ROW_WIDTH, 28, input feature-map width in pixels; must be even.
- NUM_ROWS, 28, input feature-map height in rows; must be even.
- CHANNELS, 6, parallel feature channels per pixel.
- DATA_W, 8, signed feature width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_features_valid  in  1  input pixel vector valid; no backpressure
- i_features_in  in  CHANNELS x DATA_W signed  conv feature vector for current pixel
- o_features_valid  out  1  pooled vector valid, single-cycle pulse per window
- o_features_out  out  CHANNELS x DATA_W signed  pooled feature vector
- o_frame_last  out  1  high with the final pooled vector of a frame

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: o_features_valid=0, o_frame_last=0, o_features_out all 0, col_cnt=0, row_cnt=0, held-pixel register 0, phase=FILL. Line buffer is not reset; it is always written before it is read.
- Counters:
  - col_cnt (0..ROW_WIDTH-1) and row_cnt (0..NUM_ROWS-1) advance only on cycles with i_features_valid=1.
  - col_cnt wraps to 0 after ROW_WIDTH-1 and increments row_cnt.
  - row_cnt wraps to 0 after NUM_ROWS-1; the next frame starts immediately.
  - Gaps in valid are allowed anywhere, including mid-window.
- Phase FSM:
  - FILL when row_cnt is even; EMIT when row_cnt is odd.
  - FILL->EMIT on the accepted last pixel of an even row. EMIT->FILL on the accepted last pixel of an odd row.
- Horizontal stage, per accepted pixel, per channel:
  - col even: held[c] <= i_features_in[c].
  - col odd: hmax[c] = signed max(held[c], i_features_in[c]), computed combinationally.
- FILL, col odd: line_buf[col_cnt>>1][c] <= hmax[c]. No output.
- EMIT, col odd:
  - o_features_out[c] <= signed max(line_buf[col_cnt>>1][c], hmax[c]).
  - o_features_valid <= 1.
  - o_frame_last <= 1 iff row_cnt==NUM_ROWS-1 and col_cnt==ROW_WIDTH-1.
- Latency: pooled output is registered and appears exactly 1 cycle after the accepting edge of the window's bottom-right pixel.
- o_features_valid and o_frame_last deassert the following cycle unless another window completes. o_features_out holds its value while valid is low.
- Comparisons are two's-complement signed. Equal values pass unchanged. Ties are irrelevant because values are equal.
- Per frame: (ROW_WIDTH/2)*(NUM_ROWS/2) outputs, i.e. 196 at defaults.
- Line buffer depth: ROW_WIDTH/2 entries of CHANNELS*DATA_W bits. Indexing is col_cnt>>1; no separate address pointer.
- Reset mid-frame: counters and FSM return to FILL at row 0, col 0, and outputs clear asynchronously. The next accepted pixel is treated as frame pixel (0,0).
- Elaboration: check ROW_WIDTH and NUM_ROWS are even and at least 2; fatal on violation.

Optional Feature:
- Macro: MAX_POOL_RELU_EN.
- Defined: the registered output is clamped, so any negative pooled value becomes 0 per channel. Latency is unchanged.
- Undefined: raw signed max is output, and negative values pass through.

Test Plan:
- Single 4x4 frame (ROW_WIDTH=4, NUM_ROWS=4), channel 0 pixel value = row*4+col, continuous valid -> 4 outputs on ch0: 5, 7, 13, 15. Each output is 1 cycle after pixels (1,1), (1,3), (3,1), (3,3). o_frame_last is high only with 15.
- All-negative window: ch2 pixels -128, -3, -7, -100 -> output -3 without the macro, 0 with MAX_POOL_RELU_EN.
- Random valid gaps (valid ~40% duty) on a default 28x28 frame -> exactly 196 valid pulses, values match the reference-model max. Counters never advance on invalid cycles.
- Back-to-back frames with no idle cycle -> second frame's first output equals max of its own top-left 2x2 window. No stale line-buffer data appears.
- Assert i_rst asynchronously mid-row 17 -> outputs 0 immediately. After release, the next 28x28 frame produces 196 correct outputs.
- Per-channel independence: ch0 = +127 constant, ch5 = -128 constant, other channels ramp -> ch0 always 127, ch5 always -128, ramps pooled correctly.
